// File: rtl/colour_pkg.sv
// Shared widths and state encoding for the colour-history path.
// Keeps color_detect and color_history_store agreeing on sizes.
package colour_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int ADDR_W_DEF   = 19;
    localparam int HIST_W_DEF   = 4;
    localparam int XY_W         = 10;

    typedef enum logic [1:0] {
        CLEAR      = 2'd0,
        WAIT_FRAME = 2'd1,
        RUN        = 2'd2
    } state_e;

endpackage

// File: rtl/color_history_store_if.sv
// Pixel-issue, write-back and history-read bundle between
// the video front end / colour detector and the history store.
interface color_history_store_if #(
    parameter int ADDR_W = 19,
    parameter int HIST_W = 4
);

    logic              pixel_valid;
    logic              we;
    logic [ADDR_W-1:0] write_addr;
    logic [HIST_W-1:0] updated_color_history;
    logic [ADDR_W-1:0] read_addr;
    logic [9:0]        read_x;
    logic [9:0]        read_y;
    logic [HIST_W-1:0] color_history;
    logic              color_valid;

    modport master (
        output pixel_valid, we, write_addr, updated_color_history,
        input  read_addr, read_x, read_y, color_history, color_valid
    );

    modport slave (
        input  pixel_valid, we, write_addr, updated_color_history,
        output read_addr, read_x, read_y, color_history, color_valid
    );

endinterface

// File: rtl/color_history_store_history_ram.sv
// Simple dual-port synchronous RAM, 1-cycle read.
// Read-during-write to the same address returns the old data.
module history_ram #(
    parameter int DEPTH  = 307200,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Memory array write port and registered read port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/color_history_store.sv
// Per-pixel colour-history store: counts pixels, reads history RAM,
// forwards same-cycle write-backs. Optional macro: HISTORY_CLEAR_EN.
module color_history_store
    import colour_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int HIST_W   = HIST_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 VGA_VS,
    color_history_store_if.slave bus,
    output logic                 synced
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(TOTAL - 1);

    state_e state_q, state_d;
    logic   vs_prev_q;
    logic   vs_fall;

    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              issue;
    logic [9:0]        ix, iy;
    logic [ADDR_W-1:0] iaddr;

    logic              wr_en;
    logic              fwd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [HIST_W-1:0] ram_wdata;
    logic [HIST_W-1:0] ram_rdata;

    logic              s0_valid_q;
    logic [9:0]        s0_x_q, s0_y_q;
    logic [ADDR_W-1:0] s0_addr_q;
    logic              s0_fwd_q;
    logic [HIST_W-1:0] s0_fwd_data_q;

    logic              v_q;
    logic [9:0]        rx_q, ry_q;
    logic [ADDR_W-1:0] ra_q;
    logic [HIST_W-1:0] hist_q;

    assign vs_fall = vs_prev_q & ~VGA_VS;

`ifdef HISTORY_CLEAR_EN
    localparam state_e RESET_STATE = CLEAR;
    logic clearing;
    assign clearing = (state_q == CLEAR);
`else
    localparam state_e RESET_STATE = WAIT_FRAME;
`endif

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RESET_STATE;
            vs_prev_q <= 1'b1;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            vs_prev_q <= VGA_VS;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
        end
    end

    // Next state, pixel issue and counter advance.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        issue   = 1'b0;
        ix      = x_q;
        iy      = y_q;
        iaddr   = addr_q;
        unique case (state_q)
`ifdef HISTORY_CLEAR_EN
            CLEAR: begin
                if (addr_q == A_LAST) begin
                    addr_d  = '0;
                    state_d = WAIT_FRAME;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
`endif
            WAIT_FRAME: begin
                if (vs_fall) begin
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (vs_fall) begin
                    ix     = '0;
                    iy     = '0;
                    iaddr  = '0;
                    x_d    = '0;
                    y_d    = '0;
                    addr_d = '0;
                end
                if (bus.pixel_valid) begin
                    issue = 1'b1;
                    if (ix == X_LAST) begin
                        x_d = '0;
                        y_d = (iy == Y_LAST) ? '0 : iy + 10'd1;
                    end else begin
                        x_d = ix + 10'd1;
                        y_d = iy;
                    end
                    addr_d = (iaddr == A_LAST) ? '0 : iaddr + 1'b1;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

`ifdef HISTORY_CLEAR_EN
    assign wr_en     = bus.we && !clearing
                       && (32'(bus.write_addr) < TOTAL);
    assign ram_we    = clearing | wr_en;
    assign ram_waddr = clearing ? addr_q : bus.write_addr;
    assign ram_wdata = clearing ? '0 : bus.updated_color_history;
`else
    assign wr_en     = bus.we && (32'(bus.write_addr) < TOTAL);
    assign ram_we    = wr_en;
    assign ram_waddr = bus.write_addr;
    assign ram_wdata = bus.updated_color_history;
`endif

    assign fwd = wr_en && issue && (bus.write_addr == iaddr);

    history_ram #(
        .DEPTH  (TOTAL),
        .ADDR_W (ADDR_W),
        .DATA_W (HIST_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (iaddr),
        .rdata_o (ram_rdata)
    );

    // Stage 0: capture the issued pixel alongside the RAM read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_valid_q    <= 1'b0;
            s0_x_q        <= '0;
            s0_y_q        <= '0;
            s0_addr_q     <= '0;
            s0_fwd_q      <= 1'b0;
            s0_fwd_data_q <= '0;
        end else begin
            s0_valid_q <= issue;
            if (issue) begin
                s0_x_q        <= ix;
                s0_y_q        <= iy;
                s0_addr_q     <= iaddr;
                s0_fwd_q      <= fwd;
                s0_fwd_data_q <= bus.updated_color_history;
            end
        end
    end

    // Stage 1: present the pixel, holding values while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q    <= 1'b0;
            rx_q   <= '0;
            ry_q   <= '0;
            ra_q   <= '0;
            hist_q <= '0;
        end else begin
            v_q <= s0_valid_q;
            if (s0_valid_q) begin
                rx_q   <= s0_x_q;
                ry_q   <= s0_y_q;
                ra_q   <= s0_addr_q;
                hist_q <= s0_fwd_q ? s0_fwd_data_q : ram_rdata;
            end
        end
    end

    assign bus.color_valid   = v_q;
    assign bus.read_x        = rx_q;
    assign bus.read_y        = ry_q;
    assign bus.read_addr     = ra_q;
    assign bus.color_history = hist_q;
    assign synced            = (state_q == RUN);

endmodule

// File: tb/tb_color_history_store.sv
// Directed bench for color_history_store on a 4x2 frame.
// Define HISTORY_CLEAR_EN to also exercise the CLEAR sweep.
module tb_color_history_store;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 3;
    localparam int HW = 4;

    logic clk = 1'b0;
    logic reset;
    logic VGA_VS;
    logic synced;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    color_history_store_if #(.ADDR_W(AW), .HIST_W(HW)) bus ();

    color_history_store #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW),
        .HIST_W   (HW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .VGA_VS (VGA_VS),
        .bus    (bus),
        .synced (synced)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        bus.pixel_valid = 1'b0;
        VGA_VS = 1'b0;
        tick();
        VGA_VS = 1'b1;
    endtask

    task automatic init_after_reset();
        reset = 1'b1;
`ifdef HISTORY_CLEAR_EN
        repeat (H * V + 2) tick();
`else
        for (int a = 0; a < H * V; a++) begin
            bus.we = 1'b1;
            bus.write_addr = AW'(a);
            bus.updated_color_history = '0;
            tick();
        end
        bus.we = 1'b0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        VGA_VS = 1'b1;
        bus.pixel_valid = 1'b0;
        bus.we = 1'b0;
        bus.write_addr = '0;
        bus.updated_color_history = '0;
        #2;
        reset = 1'b0;
        #2;
        checks++;
        if (bus.color_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %b want 0", bus.color_valid);
        end
        checks++;
        if (bus.read_addr !== '0) begin
            errors++;
            $display("FAIL rst_addr got %0d want 0", bus.read_addr);
        end
        checks++;
        if (bus.read_x !== '0 || bus.read_y !== '0) begin
            errors++;
            $display("FAIL rst_xy got %0d,%0d want 0,0",
                     bus.read_x, bus.read_y);
        end
        checks++;
        if (bus.color_history !== '0) begin
            errors++;
            $display("FAIL rst_hist got %0h want 0", bus.color_history);
        end
        checks++;
        if (synced !== 1'b0) begin
            errors++;
            $display("FAIL rst_synced got %b want 0", synced);
        end
        tick();
        init_after_reset();
        checks++;
        if (synced !== 1'b0) begin
            errors++;
            $display("FAIL wait_synced got %b want 0", synced);
        end
    endtask

    task automatic test_first_pixels();
        logic ev;
        frame_start();
        checks++;
        if (synced !== 1'b1) begin
            errors++;
            $display("FAIL run_synced got %b want 1", synced);
        end
        for (int i = 0; i < 6; i++) begin
            bus.pixel_valid = (i < 3);
            tick();
            ev = (i >= 1 && i <= 3);
            checks++;
            if (bus.color_valid !== ev) begin
                errors++;
                $display("FAIL first_valid i=%0d got %b want %b",
                         i, bus.color_valid, ev);
            end
            if (ev) begin
                checks++;
                if (bus.read_x !== 10'(i - 1) || bus.read_y !== 10'd0
                    || bus.read_addr !== AW'(i - 1)) begin
                    errors++;
                    $display("FAIL first_xya i=%0d got %0d,%0d,%0d want %0d,0,%0d",
                             i, bus.read_x, bus.read_y, bus.read_addr,
                             i - 1, i - 1);
                end
                checks++;
                if (bus.color_history !== 4'h0) begin
                    errors++;
                    $display("FAIL first_hist i=%0d got %0h want 0",
                             i, bus.color_history);
                end
            end
        end
        checks++;
        if (bus.read_x !== 10'd2 || bus.read_addr !== AW'(2)) begin
            errors++;
            $display("FAIL hold_xa got %0d,%0d want 2,2",
                     bus.read_x, bus.read_addr);
        end
    endtask

    task automatic test_wrap();
        int n;
        frame_start();
        for (int i = 0; i < 11; i++) begin
            bus.pixel_valid = (i < 9);
            tick();
            if (i >= 1 && i <= 9) begin
                n = i - 1;
                checks++;
                if (bus.color_valid !== 1'b1
                    || bus.read_x !== 10'(n % H)
                    || bus.read_y !== 10'((n / H) % V)
                    || bus.read_addr !== AW'(n % (H * V))) begin
                    errors++;
                    $display("FAIL wrap n=%0d got v%b %0d,%0d,%0d want v1 %0d,%0d,%0d",
                             n, bus.color_valid, bus.read_x, bus.read_y,
                             bus.read_addr, n % H, (n / H) % V, n % (H * V));
                end
            end
        end
    endtask

    task automatic test_writeback();
        bus.we = 1'b1;
        bus.write_addr = AW'(5);
        bus.updated_color_history = 4'b1011;
        tick();
        bus.we = 1'b0;
        frame_start();
        for (int i = 0; i < 8; i++) begin
            bus.pixel_valid = (i < 6);
            tick();
            if (i == 5) begin
                checks++;
                if (bus.read_addr !== AW'(4) || bus.color_history !== 4'h0) begin
                    errors++;
                    $display("FAIL wb_pix4 got a%0d h%0h want a4 h0",
                             bus.read_addr, bus.color_history);
                end
            end
            if (i == 6) begin
                checks++;
                if (bus.read_addr !== AW'(5) || bus.color_history !== 4'b1011) begin
                    errors++;
                    $display("FAIL wb_pix5 got a%0d h%0h want a5 hb",
                             bus.read_addr, bus.color_history);
                end
            end
        end
    endtask

    task automatic test_collision();
        frame_start();
        for (int i = 0; i < 6; i++) begin
            bus.pixel_valid = (i < 3);
            bus.we = (i == 1 || i == 2);
            bus.write_addr = (i == 1) ? AW'(6) : AW'(2);
            bus.updated_color_history = (i == 1) ? 4'b1111 : 4'b0110;
            tick();
            if (i == 2) begin
                checks++;
                if (bus.read_addr !== AW'(1) || bus.color_history !== 4'h0) begin
                    errors++;
                    $display("FAIL col_other got a%0d h%0h want a1 h0",
                             bus.read_addr, bus.color_history);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.read_addr !== AW'(2) || bus.color_history !== 4'b0110) begin
                    errors++;
                    $display("FAIL col_fwd got a%0d h%0h want a2 h6",
                             bus.read_addr, bus.color_history);
                end
            end
        end
        bus.we = 1'b0;
        frame_start();
        for (int i = 0; i < 5; i++) begin
            bus.pixel_valid = (i < 3);
            tick();
            if (i == 3) begin
                checks++;
                if (bus.read_addr !== AW'(2) || bus.color_history !== 4'b0110) begin
                    errors++;
                    $display("FAIL col_stored got a%0d h%0h want a2 h6",
                             bus.read_addr, bus.color_history);
                end
            end
        end
    endtask

    task automatic test_vs_midline();
        frame_start();
        for (int i = 0; i < 6; i++) begin
            bus.pixel_valid = (i < 4);
            VGA_VS = (i == 2) ? 1'b0 : 1'b1;
            tick();
            if (i == 3) begin
                checks++;
                if (bus.color_valid !== 1'b1 || bus.read_x !== 10'd0
                    || bus.read_y !== 10'd0 || bus.read_addr !== AW'(0)) begin
                    errors++;
                    $display("FAIL vs_pix got v%b %0d,%0d,%0d want v1 0,0,0",
                             bus.color_valid, bus.read_x, bus.read_y,
                             bus.read_addr);
                end
            end
            if (i == 4) begin
                checks++;
                if (bus.color_valid !== 1'b1 || bus.read_x !== 10'd1
                    || bus.read_y !== 10'd0 || bus.read_addr !== AW'(1)) begin
                    errors++;
                    $display("FAIL vs_next got v%b %0d,%0d,%0d want v1 1,0,1",
                             bus.color_valid, bus.read_x, bus.read_y,
                             bus.read_addr);
                end
            end
        end
        VGA_VS = 1'b1;
    endtask

    task automatic test_reset_midframe();
        frame_start();
        bus.pixel_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.color_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got %b want 1", bus.color_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.color_valid !== 1'b0 || synced !== 1'b0) begin
            errors++;
            $display("FAIL mid_flush got v%b s%b want v0 s0",
                     bus.color_valid, synced);
        end
        bus.pixel_valid = 1'b0;
        tick();
        init_after_reset();
    endtask

`ifdef HISTORY_CLEAR_EN
    task automatic test_clear();
        for (int a = 0; a < H * V; a++) begin
            bus.we = 1'b1;
            bus.write_addr = AW'(a);
            bus.updated_color_history = 4'b1001;
            tick();
        end
        bus.we = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < H * V; c++) begin
            bus.we = (c == 3);
            bus.write_addr = AW'(0);
            bus.updated_color_history = 4'b1111;
            checks++;
            if (synced !== 1'b0) begin
                errors++;
                $display("FAIL clr_synced c=%0d got %b want 0", c, synced);
            end
            tick();
        end
        bus.we = 1'b0;
        frame_start();
        for (int i = 0; i < H * V + 2; i++) begin
            bus.pixel_valid = (i < H * V);
            tick();
            if (i >= 1 && i <= H * V) begin
                checks++;
                if (bus.color_valid !== 1'b1 || bus.color_history !== 4'h0) begin
                    errors++;
                    $display("FAIL clr_read n=%0d got v%b h%0h want v1 h0",
                             i - 1, bus.color_valid, bus.color_history);
                end
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_first_pixels();
        test_wrap();
        test_writeback();
        test_collision();
        test_vs_midline();
        test_reset_midframe();
`ifdef HISTORY_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
